// File: rtl/huff_tree_decoder_if.sv
// huff_tree_decoder_if
//   Bit-stream input and decoded-pair output handshake bundle for
//   huff_tree_decoder.
//   axiiv/axiid/axiir : input bit valid / bit / ready (bit taken on axiiv&&axiir)
//   axiov/axior       : decoded pair valid / downstream ready
//   x_val/y_val       : signed decoded values, OUT_W bits each
//   modport slave  : the decoder side
//   modport master : the stream source / pair sink side
interface huff_tree_decoder_if #(
    parameter int OUT_W = 16
);
    logic                    axiiv;
    logic                    axiid;
    logic                    axiir;
    logic                    axiov;
    logic                    axior;
    logic signed [OUT_W-1:0] x_val;
    logic signed [OUT_W-1:0] y_val;

    modport master (
        output axiiv, axiid, axior,
        input  axiir, axiov, x_val, y_val
    );

    modport slave (
        input  axiiv, axiid, axior,
        output axiir, axiov, x_val, y_val
    );
endinterface

// File: rtl/huff_tree_decoder.sv
// huff_tree_decoder
//   Walks a binary Huffman tree held in a writable node table, one input bit
//   per step, and emits a signed (x, y) pair per codeword. Each field can be
//   extended by a linbits-wide escape value (when its base is 15) and carries
//   a sign bit when its magnitude is nonzero.
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : axiiv/axiid/axiir bit stream in, axiov/axior/x_val/y_val out
//   linbits         : escape length 0..13, sampled on the first bit of a pair
//   flush           : synchronous abandon of the pair in progress
//   err             : one-cycle pulse when a codeword exceeds MAXLEN bits
//   tbl_we/addr/wdata : node-table write port, honoured only at the tree root
//                     between pairs
//   Node word: leaf   = {1'b1, ..., x_abs[7:4], y_abs[3:0]}
//              internal = {1'b0, child1[2*AW-1:AW], child0[AW-1:0]}
module huff_tree_decoder #(
    parameter int AW     = 9,
    parameter int MAXLEN = 19,
    parameter int OUT_W  = 16,
    parameter int NODE_W = 1 + 2 * AW
) (
    input  logic              clk,
    input  logic              rst,
    huff_tree_decoder_if.slave bus,
    input  logic [3:0]        linbits,
    input  logic              flush,
    output logic              err,
    input  logic              tbl_we,
    input  logic [AW-1:0]     tbl_addr,
    input  logic [NODE_W-1:0] tbl_wdata
);

    localparam int LIN_W = 13;
    localparam int DW    = $clog2(MAXLEN + 1);

    typedef enum logic [2:0] {
        WALK,
        XLIN,
        XSIGN,
        YLIN,
        YSIGN,
        OUT
    } state_t;

    state_t state, state_n;

    logic [NODE_W-1:0] node_mem [2**AW];

    logic [AW-1:0]    ptr;
    logic [DW-1:0]    depth;
    logic [3:0]       x_abs, y_abs;
    logic [LIN_W-1:0] x_lin, y_lin;
    logic             x_neg, y_neg;
    logic [3:0]       lin_len;
    logic [3:0]       lin_cnt;

    logic             take;
    logic [AW-1:0]    child;
    logic             child_leaf;
    logic [3:0]       leaf_x, leaf_y;
    logic [3:0]       eff_lin;
    logic             leaf_hit;
    logic             overflow;
    logic             lin_done;
    logic             tbl_ok;
    logic [OUT_W-1:0] x_mag, y_mag;

    // Route past the y fields that carry no bits for this pair.
    function automatic state_t y_route(input logic [3:0] ya, input logic [3:0] lin);
        if (ya == 4'd15 && lin != 4'd0)
            return YLIN;
        else if (ya != 4'd0)
            return YSIGN;
        else
            return OUT;
    endfunction

    // Route past the x fields that carry no bits; an x_abs of 15 always has a
    // nonzero magnitude, so XLIN is always followed by XSIGN.
    function automatic state_t x_route(input logic [3:0] xa, input logic [3:0] ya,
                                       input logic [3:0] lin);
        if (xa == 4'd15 && lin != 4'd0)
            return XLIN;
        else if (xa != 4'd0)
            return XSIGN;
        else
            return y_route(ya, lin);
    endfunction

    // ------------------------------------------------------------------
    // Node table: not reset, written only at the root between pairs so a
    // walk in progress never sees a half-updated tree.
    // ------------------------------------------------------------------
    assign tbl_ok = (state == WALK) && (depth == '0);

    always_ff @(posedge clk) begin
        if (tbl_we && tbl_ok)
            node_mem[tbl_addr] <= tbl_wdata;
    end

    // ------------------------------------------------------------------
    // Handshake and tree lookup
    // ------------------------------------------------------------------
    assign bus.axiir = (state != OUT) && !flush;
    assign bus.axiov = (state == OUT);
    assign take      = bus.axiiv && bus.axiir;

    assign child      = bus.axiid ? node_mem[ptr][2*AW-1:AW] : node_mem[ptr][AW-1:0];
    assign child_leaf = node_mem[child][NODE_W-1];
    assign leaf_x     = node_mem[child][7:4];
    assign leaf_y     = node_mem[child][3:0];

    // A leaf reached on the very first bit has not latched linbits yet.
    assign eff_lin  = (depth == '0) ? linbits : lin_len;
    assign lin_done = (lin_cnt == lin_len - 4'd1);

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_n  = state;
        leaf_hit = 1'b0;
        overflow = 1'b0;
        if (flush) begin
            state_n = WALK;
        end else begin
            case (state)
                WALK: begin
                    if (take) begin
                        if (child_leaf) begin
                            leaf_hit = 1'b1;
                            state_n  = x_route(leaf_x, leaf_y, eff_lin);
                        end else if (depth == DW'(MAXLEN - 1)) begin
                            overflow = 1'b1;
                        end
                    end
                end
                XLIN:    if (take && lin_done) state_n = XSIGN;
                XSIGN:   if (take) state_n = y_route(y_abs, lin_len);
                YLIN:    if (take && lin_done) state_n = YSIGN;
                YSIGN:   if (take) state_n = OUT;
                OUT:     if (bus.axior) state_n = WALK;
                default: state_n = WALK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= WALK;
        else
            state <= state_n;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            depth   <= '0;
            x_abs   <= '0;
            y_abs   <= '0;
            x_lin   <= '0;
            y_lin   <= '0;
            x_neg   <= 1'b0;
            y_neg   <= 1'b0;
            lin_len <= '0;
            lin_cnt <= '0;
            err     <= 1'b0;
        end else begin
            err <= overflow;
            if (flush) begin
                ptr     <= '0;
                depth   <= '0;
                lin_cnt <= '0;
            end else begin
                case (state)
                    WALK: begin
                        if (take) begin
                            if (depth == '0)
                                lin_len <= linbits;
                            if (leaf_hit) begin
                                x_abs   <= leaf_x;
                                y_abs   <= leaf_y;
                                x_lin   <= '0;
                                y_lin   <= '0;
                                x_neg   <= 1'b0;
                                y_neg   <= 1'b0;
                                lin_cnt <= '0;
                                ptr     <= '0;
                                depth   <= '0;
                            end else if (overflow) begin
                                ptr   <= '0;
                                depth <= '0;
                            end else begin
                                ptr   <= child;
                                depth <= depth + DW'(1);
                            end
                        end
                    end
                    XLIN: begin
                        if (take) begin
                            x_lin   <= {x_lin[LIN_W-2:0], bus.axiid};
                            lin_cnt <= lin_done ? 4'd0 : lin_cnt + 4'd1;
                        end
                    end
                    XSIGN: if (take) x_neg <= bus.axiid;
                    YLIN: begin
                        if (take) begin
                            y_lin   <= {y_lin[LIN_W-2:0], bus.axiid};
                            lin_cnt <= lin_done ? 4'd0 : lin_cnt + 4'd1;
                        end
                    end
                    YSIGN: if (take) y_neg <= bus.axiid;
                    default: ;
                endcase
            end
        end
    end

    // Magnitudes are zero-extended before negation; the field registers are
    // frozen while in OUT, so the outputs hold until the handshake.
    assign x_mag     = OUT_W'(x_abs) + OUT_W'(x_lin);
    assign y_mag     = OUT_W'(y_abs) + OUT_W'(y_lin);
    assign bus.x_val = x_neg ? -x_mag : x_mag;
    assign bus.y_val = y_neg ? -y_mag : y_mag;

endmodule

// File: tb/tb_huff_tree_decoder.sv
module tb_huff_tree_decoder;

    localparam int AW     = 9;
    localparam int NODE_W = 1 + 2 * AW;

    typedef struct {
        int x;
        int y;
    } pair_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        linbits = 4'd0;
    logic              flush = 1'b0;
    logic              err;
    logic              tbl_we = 1'b0;
    logic [AW-1:0]     tbl_addr = '0;
    logic [NODE_W-1:0] tbl_wdata = '0;

    huff_tree_decoder_if #(.OUT_W(16)) bus ();

    huff_tree_decoder #(
        .AW(AW), .MAXLEN(19), .OUT_W(16), .NODE_W(NODE_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .linbits(linbits), .flush(flush),
        .err(err), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    err_cnt = 0;
    pair_t exp_q[$];
    logic  bp_en = 1'b0;
    logic  force_ready = 1'b1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [NODE_W-1:0] leaf(input int x, input int y);
        logic [NODE_W-1:0] w;
        w = '0;
        w[NODE_W-1] = 1'b1;
        w[7:4] = 4'(x);
        w[3:0] = 4'(y);
        return w;
    endfunction

    function automatic logic [NODE_W-1:0] intern(input int c0, input int c1);
        return {1'b0, AW'(c1), AW'(c0)};
    endfunction

    // Downstream ready: the only driver of axior.
    initial begin
        bus.axior = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.axior = bp_en ? ($urandom_range(0, 3) != 0) : force_ready;
        end
    end

    // Monitor: pops the scoreboard on every pair transfer.
    initial begin
        pair_t p;
        forever begin
            @(negedge clk);
            if (err === 1'b1) err_cnt++;
            if (!rst && !flush && bus.axiov && bus.axior) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pair actual=%0d,%0d required=none",
                             bus.x_val, bus.y_val);
                end else begin
                    p = exp_q.pop_front();
                    chk("x_val", longint'($signed(bus.x_val)), longint'(p.x));
                    chk("y_val", longint'($signed(bus.y_val)), longint'(p.y));
                end
            end
        end
    end

    task automatic write_node(input int addr, input logic [NODE_W-1:0] data);
        @(negedge clk);
        tbl_we    = 1'b1;
        tbl_addr  = AW'(addr);
        tbl_wdata = data;
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        @(negedge clk);
        bus.axiiv = 1'b1;
        bus.axiid = b;
        while (!bus.axiir && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.axiir) begin
            checks++;
            errors++;
            $display("FAIL bit_accept_timeout actual=%0d required=1", bus.axiir);
            bus.axiiv = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.axiiv = 1'b0;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_bit(s[i] == "1");
    endtask

    task automatic push(input int x, input int y);
        pair_t p;
        p.x = x;
        p.y = y;
        exp_q.push_back(p);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain_timeout actual=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Encodes one pair against the full 256-leaf heap table, where leaf
    // (x,y) has the 8-bit code x*16+y, MSB first.
    task automatic send_pair(input int xa, input int xl, input int xs,
                             input int ya, input int yl, input int ys,
                             input int lin, input bit gaps);
        logic bits[$];
        int   k, mx, my;
        k  = xa * 16 + ya;
        mx = xa + xl;
        my = ya + yl;
        push((xs != 0 && mx != 0) ? -mx : mx, (ys != 0 && my != 0) ? -my : my);
        for (int i = 7; i >= 0; i--) bits.push_back(k[i]);
        if (xa == 15 && lin > 0)
            for (int i = lin - 1; i >= 0; i--) bits.push_back(xl[i]);
        if (mx != 0) bits.push_back(xs[0]);
        if (ya == 15 && lin > 0)
            for (int i = lin - 1; i >= 0; i--) bits.push_back(yl[i]);
        if (my != 0) bits.push_back(ys[0]);
        linbits = 4'(lin);
        for (int i = 0; i < bits.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            send_bit(bits[i]);
            if (i == 0) linbits = 4'($urandom_range(0, 13));
        end
    endtask

    initial begin
        int lin, xa, ya, xl, yl;
        bus.axiiv = 1'b0;
        bus.axiid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_axiov", bus.axiov, 0);
        chk("rst_err", err, 0);
        chk("rst_x_val", bus.x_val, 0);
        chk("rst_y_val", bus.y_val, 0);
        chk("rst_axiir", bus.axiir, 1);
        rst = 1'b0;

        // Small directed tree
        write_node(0, intern(1, 2));
        write_node(1, leaf(0, 0));
        write_node(2, intern(3, 4));
        write_node(3, leaf(1, 0));
        write_node(4, leaf(15, 1));

        // Single-bit code, axiov the cycle after the bit
        push(0, 0);
        send_str("0");
        @(negedge clk);
        chk("latency_axiov", bus.axiov, 1);
        drain("zero_pair");

        push(-1, 0);
        send_str("101");
        drain("neg_one");

        linbits = 4'd4;
        push(18, -1);
        send_str("11001101");
        linbits = 4'd0;
        push(15, 1);
        send_str("1100");
        drain("escape");

        // Backpressure in OUT
        force_ready = 1'b0;
        @(posedge clk);
        #2;
        push(-1, 0);
        send_str("101");
        bus.axiiv = 1'b1;
        bus.axiid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_axiov", bus.axiov, 1);
            chk("stall_axiir", bus.axiir, 0);
            chk("stall_x_val", longint'($signed(bus.x_val)), -1);
        end
        bus.axiiv = 1'b0;
        force_ready = 1'b1;
        drain("stall");
        push(0, 0);
        send_str("0");
        drain("after_stall");

        // Table write mid-walk is ignored
        push(1, 0);
        send_str("1");
        write_node(3, leaf(7, 7));
        send_str("00");
        drain("write_ignored");

        // Overlong code
        write_node(0, intern(0, 2));
        err_cnt = 0;
        for (int i = 0; i < 18; i++) send_bit(1'b0);
        @(negedge clk);
        chk("err_before_19", err_cnt, 0);
        send_bit(1'b0);
        repeat (2) @(negedge clk);
        chk("err_pulses", err_cnt, 1);
        write_node(0, intern(1, 2));
        push(1, 0);
        send_str("100");
        drain("after_err");

        // Reset mid-pair
        send_str("1");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_axiov", bus.axiov, 0);
        rst = 1'b0;
        push(0, 0);
        send_str("0");
        drain("after_rst");

        // Flush during XLIN
        linbits = 4'd4;
        send_str("1100");
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_xlin_axiov", bus.axiov, 0);
        push(0, 0);
        send_str("0");
        drain("after_flush_xlin");

        // Flush in OUT overrides the handshake
        send_str("0");
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_out_axiov", bus.axiov, 0);
        push(-1, 0);
        send_str("101");
        drain("after_flush_out");

        // Full 256-leaf heap tree
        for (int i = 0; i < 511; i++)
            write_node(i, (i < 255) ? intern(2 * i + 1, 2 * i + 2) : leaf((i - 255) / 16, (i - 255) % 16));

        send_pair(15, 8191, 1, 15, 8191, 0, 13, 1'b0);
        send_pair(0, 0, 0, 0, 0, 0, 13, 1'b0);
        drain("max_mag");

        bp_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            lin = $urandom_range(0, 13);
            xa  = $urandom_range(0, 15);
            ya  = $urandom_range(0, 15);
            xl  = (xa == 15 && lin > 0) ? int'($urandom_range(0, (1 << lin) - 1)) : 0;
            yl  = (ya == 15 && lin > 0) ? int'($urandom_range(0, (1 << lin) - 1)) : 0;
            send_pair(xa, xl, int'($urandom_range(0, 1)), ya, yl,
                      int'($urandom_range(0, 1)), lin, 1'b1);
        end
        drain("random");
        bp_en = 1'b0;
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/huff_tree_decoder.md
HUFF_TREE_DECODER -- requirements
Module: huff_tree_decoder

Interface
REQ-001 SHALL provide parameter AW, default 9, meaning node-table address width (2^AW nodes).
REQ-002 SHALL provide parameter MAXLEN, default 19, meaning maximum codeword length before error.
REQ-003 SHALL provide parameter OUT_W, default 16, meaning signed output width.
REQ-004 SHALL provide parameter NODE_W, default 1+2*AW, meaning node-word width.
REQ-005 clk  input  1  clock; one clock.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 axiiv  input  1  input bit valid.
REQ-008 axiid  input  1  input bit.
REQ-009 axiir  output  1  ready to accept bit; a bit is consumed when axiiv&&axiir.
REQ-010 axiov  output  1  decoded pair valid.
REQ-011 axior  input  1  downstream ready; pair transferred when axiov&&axior.
REQ-012 x_val, y_val  output  OUT_W each  signed decoded values.
REQ-013 linbits  input  4  escape length 0..13; sampled on first bit of each pair.
REQ-014 flush  input  1  synchronous abandon of current pair.
REQ-015 err  output  1  one-cycle pulse on overlong code.
REQ-016 tbl_we, tbl_addr[AW-1:0], tbl_wdata[NODE_W-1:0]  input  node-table write port.

Function
REQ-017 SHALL store a 2^AW-entry node table; leaf word: bit NODE_W-1=1, [7:4]=x_abs, [3:0]=y_abs; internal word: bit NODE_W-1=0, [2*AW-1:AW]=child1, [AW-1:0]=child0; root is node 0 and is internal.
REQ-018 SHALL write tbl_wdata to tbl_addr on tbl_we only when in WALK with depth 0; otherwise the write is ignored.
REQ-019 SHALL use states WALK, XLIN, XSIGN, YLIN, YSIGN, OUT.
REQ-020 WALK: each consumed bit moves the pointer to child1 (bit 1) or child0 (bit 0); if that child is a leaf, latch x_abs/y_abs and go to XLIN in the same cycle.
REQ-021 XLIN entered only if x_abs==15 and linbits>0: consume linbits bits MSB-first into x_lin; otherwise skipped with x_lin=0.
REQ-022 XSIGN entered only if x magnitude (x_abs+x_lin) nonzero: one bit, 1 = negative; YLIN/YSIGN behave identically for y.
REQ-023 SHALL take the next state directly past skipped states in the same cycle; no idle cycles between fields.
REQ-024 OUT: axiov=1, axiir=0; x_val/y_val stable until handshake; on handshake go to WALK at root, depth 0, next cycle.
REQ-025 SHALL assert axiov the cycle after the last bit of a pair is consumed.
REQ-026 SHALL hold axiir=1 in all states except OUT and when flush=1.
REQ-027 x_val = sign ? -(x_abs+x_lin) : (x_abs+x_lin), zero-extended before negation; same for y_val; max magnitude 8206.
REQ-028 WALK depth counter SHALL increment per consumed bit; if MAXLEN bits consumed without reaching a leaf, pulse err, return to root, depth 0.
REQ-029 flush=1 SHALL return to WALK at root next cycle from any state, deassert axiov, drop any concurrent input bit; flush overrides the axior handshake.
REQ-030 linbits changes mid-pair SHALL not affect the pair in progress.

Reset
REQ-031 On rst: state WALK, pointer 0, depth 0, axiov=0, err=0, x_val=0, y_val=0, counters and sign/linval registers 0; node table contents retained, not reset.
REQ-032 rst mid-pair SHALL discard the partial pair; no axiov for it after release.

Verification
Table for all: n0 internal c0=1 c1=2; n1 leaf(0,0); n2 internal c0=3 c1=4; n3 leaf(1,0); n4 leaf(15,1); axior=1 unless stated.
REQ-033 Bits "0" -> axiov next cycle, x_val=0, y_val=0, no sign bits consumed.
REQ-034 Bits "10","1" -> x_val=-1, y_val=0.
REQ-035 linbits=4; bits "11","0011","0","1" -> x_val=18, y_val=-1; with linbits=0 bits "11","0","0" -> x_val=15, y_val=1.
REQ-036 axior=0 for 3 cycles in OUT -> axiov held, axiir=0, values stable; bits offered meanwhile not consumed.
REQ-037 Rewrite n0 with c0=0; feed 19 zero bits -> err pulses once on the 19th; next "1","0","0" decodes x_val=1, y_val=0 after n0 restored.
REQ-038 Assert rst after "1" of "10" -> after release, "0" yields (0,0); flush during XLIN likewise yields no output for the abandoned pair.
